mm_bridge: RTL and testbench
============================

# mm_bridge

Main-memory bridge between the core's external memory bus (MMA, MMnWR, MMD_Out, MM_CE, MM_New_Line, MMD_In) and a request/acknowledge memory slave. The core issues a line request. The bridge then runs a critical-word-first, wrapping burst of LINE_WORDS beats on the slave port. Read data returns on MMD_In, and each completed beat is flagged to the core with a one-cycle strobe.

## Interface
- LINE_WORDS, 4, beats per line; power of two, 1..16
- TIMEOUT_CYCLES, 255, maximum ACK wait per beat; used only with MM_BRIDGE_TIMEOUT_EN
- GCLK  in  1  clock; all logic on rising edge
- RESET  in  1  reset; synchronous, active-high
- MMA  in  32  core line address; bits [1:0] ignored
- MMnWR  in  1  1 = read burst, 0 = write burst; sampled at burst start
- MMD_Out  in  32  core write data for the current beat
- MM_CE  in  1  core memory enable
- MM_New_Line  in  1  start new line access (qualified by MM_CE)
- MMD_In  out  32  read data to core; holds last read beat
- MM_VALID  out  1  one-cycle strobe per completed beat
- MM_DONE  out  1  one-cycle strobe on final (or aborted) beat
- MM_BUSY  out  1  burst in progress
- MM_ERR  out  1  one-cycle timeout strobe
- MEM_REQ  out  1  slave request
- MEM_WE  out  1  slave write enable
- MEM_ADDR  out  32  slave word address (byte address, [1:0]=0)
- MEM_WDATA  out  32  slave write data
- MEM_RDATA  in  32  slave read data, valid with MEM_ACK
- MEM_ACK  in  1  slave acknowledge

## Operation
- States:
  - IDLE: waits for a start request.
  - REQ: MEM_REQ=1, waiting for MEM_ACK.
  - RESP: beat complete.
- IDLE→REQ when MM_CE=1 and MM_New_Line=1. On this transition the bridge:
  - latches the base address {MMA[31:2+log2 LINE_WORDS], 0} and the start index MMA[2+:log2 LINE_WORDS];
  - latches MMnWR into MEM_WE as ~MMnWR;
  - captures MMD_Out into MEM_WDATA;
  - clears the beat counter k.
- MEM_ADDR for beat k = base + (((start + k) mod LINE_WORDS) << 2). The index arithmetic wraps within the line.
- REQ: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable until MEM_ACK=1 is sampled. On ACK the state goes to RESP, and for a read MEM_RDATA is registered into MMD_In.
- RESP: MEM_REQ=0 and MM_VALID=1.
  - If k = LINE_WORDS−1 or MM_CE=0: MM_DONE=1, next state IDLE.
  - Otherwise: k increments, MMD_Out is captured into MEM_WDATA as the next beat's data, next state REQ.
- The core must drive write data for beat k+1 on MMD_Out during the cycle MM_VALID for beat k is high.
- MM_BUSY=1 in REQ and RESP. It is 0 in IDLE, including the cycle MM_DONE is high.
- MM_New_Line while busy is ignored.
- MM_CE=1 with MM_New_Line=0 in IDLE does nothing.
- MM_CE deasserting during REQ has no effect until RESP. The current beat always completes.
- MMD_In is unchanged by write beats.

## Timing
- Reset value of every output is 0, including MMD_In, MEM_ADDR and MEM_WDATA. State is IDLE and k=0.
- RESET mid-burst: state is IDLE and MEM_REQ=0 on the next edge. A late MEM_ACK is ignored.
- Start request at cycle t puts MEM_REQ=1 at t+1.
- ACK sampled at cycle u gives MM_VALID (and MMD_In for a read) at u+1. The next beat's MEM_REQ is high at u+2.
- Zero-wait slave (ACK in the first REQ cycle): 2 cycles per beat, 8 cycles for a 4-word line.
- MEM_ACK outside REQ is ignored.

## Configuration
- MM_BRIDGE_TIMEOUT_EN defined:
  - An 8-bit-minimum counter clears on entering REQ and increments each REQ cycle with MEM_ACK=0.
  - When it reaches TIMEOUT_CYCLES: MEM_REQ drops, MM_ERR=1 and MM_DONE=1 for one cycle, MM_VALID=0, MMD_In is unchanged, next state IDLE.
  - MEM_ACK=1 in the same cycle the count would expire wins: it is a normal beat with no error.
- Not defined: REQ waits indefinitely, MM_ERR is tied 0, and no counter is built.

## Test plan
- Read line, MMA=0x00001008, ACK one cycle after each REQ:
  - MEM_ADDR sequence is 0x1008, 0x100C, 0x1000, 0x1004.
  - MMD_In follows MEM_RDATA per beat.
  - MM_VALID ×4, MM_DONE with the 4th beat.
- Write line, MMnWR=0, MMA=0x2000, core supplies 0xA0..0xA3:
  - MEM_WE=1 and MEM_WDATA=0xA0..0xA3 at 0x2000..0x200C.
  - MMD_In stays unchanged.
- Zero-wait read with ACK held high: MM_VALID on alternate cycles, MM_BUSY high for 8 cycles, and MM_DONE 8 cycles after MEM_REQ first rises.
- MM_CE dropped after the beat-1 MM_VALID: beat 2 completes, then MM_DONE, IDLE, and no beat 3. MM_New_Line pulsed mid-burst is ignored.
- RESET asserted while in REQ on beat 2: MEM_REQ=0 and all outputs 0 on the next cycle. An ACK the cycle after produces no MM_VALID.
- With MM_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ACK: MM_ERR and MM_DONE pulse 16 REQ cycles after MEM_REQ rises, then IDLE. Repeating with ACK on cycle 16 gives a normal beat and MM_ERR=0.

Source files
------------

// File: rtl/mm_bridge.sv
// mm_bridge
// Bridges the core's main-memory line interface onto a request/acknowledge
// memory slave. A line request is turned into a burst of LINE_WORDS beats.
// The burst starts at the requested word and wraps within the line.
//
// Parameters
//   LINE_WORDS     beats per line (power of two, 1..16)
//   TIMEOUT_CYCLES maximum ACK wait per beat (only with MM_BRIDGE_TIMEOUT_EN)
//
// Build option
//   MM_BRIDGE_TIMEOUT_EN  when defined, a beat that waits TIMEOUT_CYCLES REQ
//                         cycles without ACK is abandoned. MM_ERR and MM_DONE
//                         pulse and the bridge returns to IDLE. When not
//                         defined, REQ waits forever and MM_ERR is tied low.
//
// Ports
//   GCLK, RESET        clock, synchronous active-high reset
//   MMA, MMnWR         core line address, read(1)/write(0) select
//   MMD_Out            core write data for the current beat
//   MM_CE, MM_New_Line core enable, line start request
//   MMD_In             last read beat returned to the core
//   MM_VALID           one-cycle strobe per completed beat
//   MM_DONE            one-cycle strobe on the first IDLE cycle after the
//                      final, CE-aborted or timed-out beat
//   MM_BUSY            burst in progress (REQ or RESP)
//   MM_ERR             one-cycle timeout strobe
//   MEM_REQ, MEM_WE    slave request, slave write enable
//   MEM_ADDR           slave byte address, word aligned
//   MEM_WDATA          slave write data
//   MEM_RDATA, MEM_ACK slave read data, slave acknowledge
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no burst; waits for MM_CE & MM_New_Line
// REQ   | MEM_REQ high; address/data held until MEM_ACK is sampled
// RESP  | beat complete; MM_VALID high; continue, or finish the burst

module mm_bridge #(
   parameter int LINE_WORDS     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        GCLK,
   input  logic        RESET,
   input  logic [31:0] MMA,
   input  logic        MMnWR,
   input  logic [31:0] MMD_Out,
   input  logic        MM_CE,
   input  logic        MM_New_Line,
   output logic [31:0] MMD_In,
   output logic        MM_VALID,
   output logic        MM_DONE,
   output logic        MM_BUSY,
   output logic        MM_ERR,
   output logic        MEM_REQ,
   output logic        MEM_WE,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK
);

   localparam int IDX_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_MASK  = IDX_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);
   // byte-offset bits inside one line; clearing them gives the line base
   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_t;

   state_t           state;
   logic [31:0]      base_addr;
   logic [IDX_W-1:0] start_idx;
   logic [IDX_W-1:0] beat_k;
   logic [IDX_W-1:0] next_k;
   logic [IDX_W-1:0] mma_idx;
   logic             last_beat;

   assign next_k    = beat_k + IDX_W'(1);
   assign mma_idx   = MMA[2 +: IDX_W] & IDX_MASK;
   assign last_beat = (beat_k == LAST_BEAT);

   // Word index wraps inside the line because the sum is masked to the
   // line size, so the burst never leaves the line.
   function automatic logic [31:0] beat_addr(input logic [31:0]      base,
                                             input logic [IDX_W-1:0] start,
                                             input logic [IDX_W-1:0] k);
      logic [IDX_W-1:0] idx;
      idx = (start + k) & IDX_MASK;
      return base | (32'(idx) << 2);
   endfunction

`ifdef MM_BRIDGE_TIMEOUT_EN
   localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   // Expire on the last permitted REQ cycle so the error strobe lands
   // exactly TIMEOUT_CYCLES cycles after MEM_REQ rises.
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt;
`else
   assign MM_ERR = 1'b0;
`endif

   always_ff @(posedge GCLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         base_addr <= '0;
         start_idx <= '0;
         beat_k    <= '0;
         MMD_In    <= '0;
         MM_VALID  <= 1'b0;
         MM_DONE   <= 1'b0;
         MM_BUSY   <= 1'b0;
         MEM_REQ   <= 1'b0;
         MEM_WE    <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
`ifdef MM_BRIDGE_TIMEOUT_EN
         MM_ERR    <= 1'b0;
         to_cnt    <= '0;
`endif
      end else begin
         MM_VALID <= 1'b0;
         MM_DONE  <= 1'b0;
`ifdef MM_BRIDGE_TIMEOUT_EN
         MM_ERR   <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (MM_CE && MM_New_Line) begin
                  state     <= ST_REQ;
                  MEM_REQ   <= 1'b1;
                  MM_BUSY   <= 1'b1;
                  MEM_WE    <= ~MMnWR;
                  MEM_WDATA <= MMD_Out;
                  base_addr <= MMA & ~LINE_MASK;
                  start_idx <= mma_idx;
                  beat_k    <= '0;
                  MEM_ADDR  <= beat_addr(MMA & ~LINE_MASK, mma_idx, '0);
`ifdef MM_BRIDGE_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end

            ST_REQ: begin
               // ACK takes priority over an expiring timeout in the same cycle
               if (MEM_ACK) begin
                  state    <= ST_RESP;
                  MEM_REQ  <= 1'b0;
                  MM_VALID <= 1'b1;
                  if (!MEM_WE) begin
                     MMD_In <= MEM_RDATA;
                  end
               end
`ifdef MM_BRIDGE_TIMEOUT_EN
               else if (to_cnt == TO_LIMIT) begin
                  state   <= ST_IDLE;
                  MEM_REQ <= 1'b0;
                  MM_BUSY <= 1'b0;
                  MM_ERR  <= 1'b1;
                  MM_DONE <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end

            ST_RESP: begin
               // Dropping MM_CE only takes effect here, so the beat in
               // flight always completes before the burst is cut short.
               if (last_beat || !MM_CE) begin
                  state   <= ST_IDLE;
                  MM_BUSY <= 1'b0;
                  MM_DONE <= 1'b1;
               end else begin
                  state     <= ST_REQ;
                  MEM_REQ   <= 1'b1;
                  beat_k    <= next_k;
                  MEM_ADDR  <= beat_addr(base_addr, start_idx, next_k);
                  MEM_WDATA <= MMD_Out;
`ifdef MM_BRIDGE_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end

            default: begin
               state   <= ST_IDLE;
               MEM_REQ <= 1'b0;
               MM_BUSY <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mm_bridge.sv
module tb_mm_bridge;

   localparam int LW = 4;
   localparam int TO = 16;

   logic        GCLK = 1'b0;
   logic        RESET;
   logic [31:0] MMA;
   logic        MMnWR;
   logic [31:0] MMD_Out;
   logic        MM_CE;
   logic        MM_New_Line;
   logic [31:0] MMD_In;
   logic        MM_VALID;
   logic        MM_DONE;
   logic        MM_BUSY;
   logic        MM_ERR;
   logic        MEM_REQ;
   logic        MEM_WE;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic [31:0] MEM_RDATA;
   logic        MEM_ACK;

   int errors = 0;
   int checks = 0;
   logic [31:0] mmd_exp = '0;      // model of the last read beat seen by the core
   logic [31:0] wdat [LW];          // core write data per beat for the next burst

   mm_bridge #(.LINE_WORDS(LW), .TIMEOUT_CYCLES(TO)) dut (
      .GCLK(GCLK), .RESET(RESET), .MMA(MMA), .MMnWR(MMnWR), .MMD_Out(MMD_Out),
      .MM_CE(MM_CE), .MM_New_Line(MM_New_Line), .MMD_In(MMD_In),
      .MM_VALID(MM_VALID), .MM_DONE(MM_DONE), .MM_BUSY(MM_BUSY), .MM_ERR(MM_ERR),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
   );

   always #5 GCLK = ~GCLK;

   task automatic test_reset();
      RESET = 1'b1; MMA = '0; MMnWR = 1'b1; MMD_Out = '0; MM_CE = 1'b0;
      MM_New_Line = 1'b0; MEM_RDATA = '0; MEM_ACK = 1'b0;
      repeat (2) @(negedge GCLK);
      checks++;
      if ({MMD_In, MM_VALID, MM_DONE, MM_BUSY, MM_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got mmd_in=%h valid=%b done=%b busy=%b err=%b req=%b we=%b addr=%h wdata=%h exp all 0",
                  MMD_In, MM_VALID, MM_DONE, MM_BUSY, MM_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA);
      end
      RESET = 1'b0;
      mmd_exp = '0;
   endtask

   task automatic test_idle_ce();
      for (int c = 0; c < 4; c++) begin
         @(negedge GCLK);
         MM_CE = 1'b1; MM_New_Line = 1'b0; MEM_ACK = 1'($urandom_range(1, 0));
         checks++;
         if (MEM_REQ !== 1'b0 || MM_BUSY !== 1'b0 || MM_VALID !== 1'b0) begin
            errors++;
            $display("FAIL idle_ce: got req=%b busy=%b valid=%b exp 0 0 0", MEM_REQ, MM_BUSY, MM_VALID);
         end
      end
      @(negedge GCLK);
      MM_CE = 1'b0; MEM_ACK = 1'b0;
   endtask

   // One complete line transfer, driven and checked cycle by cycle.
   // ce_last: last 0-based beat index during whose RESP MM_CE is still 1.
   task automatic do_burst(input string tag, input logic [31:0] addr, input bit rd,
                           input int ce_last, input int min_wait, input int max_wait,
                           input bit ack_hold);
      int          idx, w, busy_cyc, exp_busy;
      logic [31:0] ea, rdata;
      bit          last;
      busy_cyc = 0; exp_busy = 0; rdata = '0;
      @(negedge GCLK);
      MMA = addr; MMnWR = rd; MM_CE = 1'b1; MM_New_Line = 1'b1;
      MMD_Out = wdat[0]; MEM_ACK = ack_hold;
      for (int k = 0; k < LW; k++) begin
         idx = (int'(addr[3:2]) + k) % LW;
         ea  = {addr[31:4], 4'h0} + 32'(idx * 4);
         w   = ack_hold ? 0 : int'($urandom_range(max_wait, min_wait));
         exp_busy += w + 2;
         for (int c = 0; c <= w; c++) begin
            @(negedge GCLK);
            if (c == 0) begin
               MM_New_Line = (k > 0) ? 1'($urandom_range(1, 0)) : 1'b0;
               if (k > ce_last) MM_CE = 1'b0;
            end else begin
               MM_New_Line = 1'b0;
            end
            checks++;
            if (MEM_REQ !== 1'b1 || MM_BUSY !== 1'b1 || MM_VALID !== 1'b0 || MEM_ADDR !== ea || MEM_WE !== !rd) begin
               errors++;
               $display("FAIL %s req_beat%0d: got req=%b busy=%b valid=%b addr=%h we=%b exp 1 1 0 %h %b",
                        tag, k, MEM_REQ, MM_BUSY, MM_VALID, MEM_ADDR, MEM_WE, ea, !rd);
            end
            if (!rd) begin
               checks++;
               if (MEM_WDATA !== wdat[k]) begin
                  errors++;
                  $display("FAIL %s wdata_beat%0d: got %h exp %h", tag, k, MEM_WDATA, wdat[k]);
               end
            end
            busy_cyc++;
            if (c == w) begin
               MEM_ACK = 1'b1; MEM_RDATA = $urandom; rdata = MEM_RDATA;
            end else begin
               MEM_ACK = 1'b0; MEM_RDATA = $urandom;
            end
         end
         @(negedge GCLK);
         if (rd) mmd_exp = rdata;
         checks++;
         if (MM_VALID !== 1'b1 || MEM_REQ !== 1'b0 || MM_BUSY !== 1'b1 || MM_DONE !== 1'b0 || MMD_In !== mmd_exp) begin
            errors++;
            $display("FAIL %s resp_beat%0d: got valid=%b req=%b busy=%b done=%b mmd_in=%h exp 1 0 1 0 %h",
                     tag, k, MM_VALID, MEM_REQ, MM_BUSY, MM_DONE, MMD_In, mmd_exp);
         end
         busy_cyc++;
         MM_New_Line = 1'b0; MEM_RDATA = $urandom;
         if (!ack_hold) MEM_ACK = 1'b0;
         if (k + 1 < LW) MMD_Out = wdat[k + 1];
         last = (k == LW - 1) || (k > ce_last);
         if (last) begin
            @(negedge GCLK);
            checks++;
            if (MM_DONE !== 1'b1 || MM_BUSY !== 1'b0 || MM_VALID !== 1'b0 || MEM_REQ !== 1'b0 || MM_ERR !== 1'b0) begin
               errors++;
               $display("FAIL %s done: got done=%b busy=%b valid=%b req=%b err=%b exp 1 0 0 0 0",
                        tag, MM_DONE, MM_BUSY, MM_VALID, MEM_REQ, MM_ERR);
            end
            checks++;
            if (busy_cyc !== exp_busy || (ack_hold && busy_cyc !== 2 * LW)) begin
               errors++;
               $display("FAIL %s busy_cycles: got %0d exp %0d", tag, busy_cyc, exp_busy);
            end
            @(negedge GCLK);
            checks++;
            if (MM_DONE !== 1'b0 || MEM_REQ !== 1'b0 || MM_BUSY !== 1'b0 || MMD_In !== mmd_exp) begin
               errors++;
               $display("FAIL %s after_done: got done=%b req=%b busy=%b mmd_in=%h exp 0 0 0 %h",
                        tag, MM_DONE, MEM_REQ, MM_BUSY, MMD_In, mmd_exp);
            end
            MM_CE = 1'b0; MEM_ACK = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_read_line();
      do_burst("read_1008", 32'h0000_1008, 1'b1, LW, 1, 1, 1'b0);
   endtask

   task automatic test_write_line();
      for (int i = 0; i < LW; i++) wdat[i] = 32'hA0 + 32'(i);
      do_burst("write_2000", 32'h0000_2000, 1'b0, LW, 0, 3, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_burst("zero_wait", 32'h0000_4004, 1'b1, LW, 0, 0, 1'b1);
   endtask

   task automatic test_ce_drop();
      for (int i = 0; i < LW; i++) wdat[i] = $urandom;
      do_burst("ce_drop", 32'h0000_500C, 1'b1, 0, 0, 2, 1'b0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < LW; i++) wdat[i] = $urandom;
         do_burst("random", $urandom, 1'($urandom_range(1, 0)), int'($urandom_range(LW, 0)), 0, 3, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rdata;
      @(negedge GCLK);
      MMA = 32'h0000_3004; MMnWR = 1'b1; MM_CE = 1'b1; MM_New_Line = 1'b1;
      @(negedge GCLK);
      MM_New_Line = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = $urandom; rdata = MEM_RDATA;
      @(negedge GCLK);
      MEM_ACK = 1'b0;
      checks++;
      if (MM_VALID !== 1'b1 || MMD_In !== rdata) begin
         errors++;
         $display("FAIL reset_mid_beat1: got valid=%b mmd_in=%h exp 1 %h", MM_VALID, MMD_In, rdata);
      end
      @(negedge GCLK);
      checks++;
      if (MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h0000_3008) begin
         errors++;
         $display("FAIL reset_mid_req2: got req=%b addr=%h exp 1 00003008", MEM_REQ, MEM_ADDR);
      end
      RESET = 1'b1;
      @(negedge GCLK);
      mmd_exp = '0;
      checks++;
      if ({MMD_In, MM_VALID, MM_DONE, MM_BUSY, MM_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got mmd_in=%h valid=%b done=%b busy=%b err=%b req=%b we=%b addr=%h wdata=%h exp all 0",
                  MMD_In, MM_VALID, MM_DONE, MM_BUSY, MM_ERR, MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA);
      end
      RESET = 1'b0; MEM_ACK = 1'b1; MEM_RDATA = $urandom;
      @(negedge GCLK);
      MEM_ACK = 1'b0; MM_CE = 1'b0;
      checks++;
      if (MM_VALID !== 1'b0 || MEM_REQ !== 1'b0 || MM_BUSY !== 1'b0 || MMD_In !== mmd_exp) begin
         errors++;
         $display("FAIL reset_mid_late_ack: got valid=%b req=%b busy=%b mmd_in=%h exp 0 0 0 %h",
                  MM_VALID, MEM_REQ, MM_BUSY, MMD_In, mmd_exp);
      end
   endtask

`ifdef MM_BRIDGE_TIMEOUT_EN
   // ack_at < 0: no ACK at all; otherwise ACK in that 0-based REQ cycle.
   task automatic test_timeout(input int ack_at);
      logic [31:0] rdata;
      rdata = '0;
      @(negedge GCLK);
      MMA = 32'h0000_6000; MMnWR = 1'b1; MM_CE = 1'b1; MM_New_Line = 1'b1; MEM_ACK = 1'b0;
      for (int c = 0; c < TO; c++) begin
         @(negedge GCLK);
         MM_New_Line = 1'b0;
         checks++;
         if (MEM_REQ !== 1'b1 || MM_ERR !== 1'b0 || MM_DONE !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait%0d: got req=%b err=%b done=%b exp 1 0 0", c, MEM_REQ, MM_ERR, MM_DONE);
         end
         if (c == ack_at) begin
            MEM_ACK = 1'b1; MEM_RDATA = $urandom; rdata = MEM_RDATA;
         end
      end
      @(negedge GCLK);
      MEM_ACK = 1'b0; MM_CE = 1'b0;
      if (ack_at == TO - 1) mmd_exp = rdata;
      checks++;
      if (ack_at < 0) begin
         if (MM_ERR !== 1'b1 || MM_DONE !== 1'b1 || MEM_REQ !== 1'b0 || MM_VALID !== 1'b0 || MM_BUSY !== 1'b0 || MMD_In !== mmd_exp) begin
            errors++;
            $display("FAIL timeout_expire: got err=%b done=%b req=%b valid=%b busy=%b mmd_in=%h exp 1 1 0 0 0 %h",
                     MM_ERR, MM_DONE, MEM_REQ, MM_VALID, MM_BUSY, MMD_In, mmd_exp);
         end
      end else begin
         if (MM_ERR !== 1'b0 || MM_VALID !== 1'b1 || MMD_In !== mmd_exp) begin
            errors++;
            $display("FAIL timeout_ack_wins: got err=%b valid=%b mmd_in=%h exp 0 1 %h", MM_ERR, MM_VALID, MMD_In, mmd_exp);
         end
      end
      @(negedge GCLK);
      checks++;
      if (MM_ERR !== 1'b0 || MEM_REQ !== 1'b0 || (ack_at >= 0 && MM_DONE !== 1'b1)) begin
         errors++;
         $display("FAIL timeout_after: got err=%b req=%b done=%b", MM_ERR, MEM_REQ, MM_DONE);
      end
      @(negedge GCLK);
   endtask
`endif

   initial begin
      test_reset();
      test_idle_ce();
      test_read_line();
      test_write_line();
      test_back_to_back();
      test_ce_drop();
      test_random();
      test_reset_mid();
`ifdef MM_BRIDGE_TIMEOUT_EN
      test_timeout(-1);
      test_timeout(TO - 1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
